// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the requester-FIFO arbitration logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: arbiter FSM state encoding, burst counter width/type, and a
// helper that sizes a requester index field.
package fifo_ctrl_pkg;

    // Arbiter ownership state: SCAN = no current owner, HOLD = owner bursting.
    typedef enum logic {
        SCAN = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Burst counter is a fixed 8-bit field, which bounds MAX_BURST to 255.
    localparam int BURST_W = 8;
    typedef logic [BURST_W-1:0] burst_cnt_t;

    // Width of an index into n requesters, never less than one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular priority picker: first set request at or after a start index.
// Latency: purely combinational.
// Backpressure: none; caller decides whether to act on the result.
//
// Ports:
//   req_i   - request vector, one bit per requester
//   start_i - index that has highest priority this cycle
//   found_o - at least one request bit is set
//   idx_o   - winning index (0 when found_o is low)
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = src_width(4)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Candidate index for each priority position, wrapping past N-1 to 0.
    // The modulo keeps every candidate inside 0..N-1 even when N is not a
    // power of two.
    logic [IDX_W-1:0] cand [N];

    for (genvar i = 0; i < N; i++) begin : g_cand
        assign cand[i] = IDX_W'((int'(start_i) + i) % N);
    end

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = 0; i < N; i++) begin
            if (!found_o && req_i[cand[i]]) begin
                found_o = 1'b1;
                idx_o   = cand[i];
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining NUM_REQ requester FIFOs into one output register, with bursts.
// Latency: 1 cycle from grant (req_consume pulse) to out_data/out_valid.
// Backpressure: no grant while out_valid=1 and out_ready=0; output word held until accepted.
//
// Ports:
//   clk, rst     - clock (rising edge), asynchronous active-high reset
//   en           - arbitration enable; when low no new grants are issued
//   req_empty    - per-requester FIFO empty flags
//   req_data     - flattened FIFO heads, requester k at [k*FIFO_width +: FIFO_width]
//   req_consume  - one-hot-or-zero pop strobe back to the requester FIFOs
//   out_data     - registered granted word
//   out_valid    - out_data holds an undelivered word
//   out_ready    - downstream accepts out_data this cycle
//   out_src      - index of the requester that supplied out_data
module fifo_rr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_width = 64,
    parameter  int MAX_BURST  = 4,
    localparam int SRC_W      = src_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_empty,
    input  logic [NUM_REQ*FIFO_width-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_consume,
    output logic [FIFO_width-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SRC_W-1:0]              out_src
);

    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);
    localparam burst_cnt_t       MAX_B    = burst_cnt_t'(MAX_BURST);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e              state_q,      state_d;
    logic [SRC_W-1:0]        last_owner_q, last_owner_d;
    burst_cnt_t              burst_cnt_q,  burst_cnt_d;
    logic                    out_valid_q,  out_valid_d;
    logic [FIFO_width-1:0]   out_data_q,   out_data_d;
    logic [SRC_W-1:0]        out_src_q,    out_src_d;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    logic                  slot_free;
    logic [NUM_REQ-1:0]    nonempty;
    logic [SRC_W-1:0]      start_idx;
    logic                  pick_found;
    logic [SRC_W-1:0]      pick_idx;
    logic                  owner_ok;
    logic                  grant_vld;
    logic [SRC_W-1:0]      grant_idx;
    logic [FIFO_width-1:0] grant_word;

    assign slot_free = ~out_valid_q | out_ready;
    assign nonempty  = ~req_empty;

    // Search always starts just after the last owner. In HOLD this puts the
    // owner at the lowest priority, so it only wins the search when it is the
    // sole non-empty requester; in SCAN it gives plain round-robin order.
    assign start_idx = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + SRC_W'(1);

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req_i   (nonempty),
        .start_i (start_idx),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Owner keeps the slot while it has data and its burst budget remains.
    assign owner_ok = (state_q == HOLD) && nonempty[last_owner_q] && (burst_cnt_q < MAX_B);

    assign grant_vld = en && slot_free && (owner_ok || pick_found);
    assign grant_idx = owner_ok ? last_owner_q : pick_idx;

    assign grant_word = req_data[int'(grant_idx)*FIFO_width +: FIFO_width];

    // Pop strobe is combinational so the FIFO advances on the same edge that
    // captures its head; it is forced low while reset is asserted.
    always_comb begin
        req_consume = '0;
        if (grant_vld && !rst) begin
            req_consume[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_src_d    = out_src_q;

        if (grant_vld) begin
            state_d      = HOLD;
            last_owner_d = grant_idx;
            // A re-grant extends the burst; any search win (including the
            // owner winning as sole requester) starts a fresh burst.
            burst_cnt_d  = owner_ok ? burst_cnt_q + burst_cnt_t'(1) : burst_cnt_t'(1);
            out_valid_d  = 1'b1;
            out_data_d   = grant_word;
            out_src_d    = grant_idx;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Nothing to serve with the slot open: drop ownership but keep
            // last_owner so the next search continues the rotation.
            if (en && slot_free && !pick_found) begin
                state_d     = SCAN;
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SCAN;
            last_owner_q <= LAST_IDX;
            burst_cnt_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_src_q    <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: behavioural requester FIFOs plus an output scoreboard.
// Latency: expects output one cycle after each req_consume.
// Backpressure: drives out_ready/en per scenario and checks holding behaviour.
module tb_fifo_rr_arbiter;

    localparam int NR = 4;
    localparam int W  = 64;
    localparam int MB = 2;
    localparam int SW = 2;

    typedef struct {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } beat_t;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            en        = 1'b0;
    logic [NR-1:0]   req_empty = '1;
    logic [NR*W-1:0] req_data  = '0;
    logic            out_ready = 1'b0;
    logic [NR-1:0]   req_consume;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic [SW-1:0]   out_src;

    logic [W-1:0] fifo_q [NR][$];   // contents seen by the DUT
    logic [W-1:0] ref_q  [NR][$];   // same words, consumed when building expectations
    beat_t        exp_q  [$];

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int nbeats    = 0;
    int seq_no    = 0;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(
        .NUM_REQ    (NR),
        .FIFO_width (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req_empty   (req_empty),
        .req_data    (req_data),
        .req_consume (req_consume),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_src     (out_src)
    );

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int k = 0; k < NR; k++) begin
            req_empty[k]       = (fifo_q[k].size() == 0);
            req_data[k*W +: W] = (fifo_q[k].size() == 0) ? '0 : fifo_q[k][0];
        end
    endtask

    task automatic load(input int k, input int n);
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = {$urandom(), 8'(k), 24'(seq_no)};
            seq_no++;
            fifo_q[k].push_back(d);
            ref_q[k].push_back(d);
        end
        refresh();
    endtask

    task automatic expect_src(input int k);
        beat_t b;
        b.src  = SW'(k);
        b.data = ref_q[k].pop_front();
        exp_q.push_back(b);
    endtask

    task automatic clear_stats();
        first_cyc = -1;
        last_cyc  = -1;
        nbeats    = 0;
    endtask

    // One clock: observe at the falling edge, then model FIFO pops just after
    // the rising edge.
    task automatic cycle();
        logic [NR-1:0] cons;
        beat_t         e;
        @(negedge clk);
        cyc++;
        cons = req_consume;
        if (cons != '0) begin
            check_eq("consume_onehot", W'($onehot(cons)), W'(1));
            check_eq("consume_nonempty", W'(cons & req_empty), '0);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("out_valid_unexpected", W'(out_valid), '0);
            end else begin
                e = exp_q.pop_front();
                check_eq("beat_src", W'(out_src), W'(e.src));
                check_eq("beat_data", out_data, e.data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (cons[k] && fifo_q[k].size() != 0) void'(fifo_q[k].pop_front());
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        check_eq(tag, W'(exp_q.size()), '0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < NR; k++) begin
            fifo_q[k].delete();
            ref_q[k].delete();
        end
        exp_q.delete();
        refresh();
        clear_stats();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t37 [9] = '{1, 1, 3, 3, 1, 1, 3, 3, 1};

        // Reset state, with requests already pending.
        en        = 1'b1;
        out_ready = 1'b1;
        load(0, 2);
        load(2, 1);
        #12;
        check_eq("rst_valid",   W'(out_valid),   '0);
        check_eq("rst_data",    out_data,        '0);
        check_eq("rst_src",     W'(out_src),     '0);
        check_eq("rst_consume", W'(req_consume), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // First grant goes to the lowest index, burst of MB, then on to 2.
        expect_src(0);
        expect_src(0);
        expect_src(2);
        drain("s0_drain", 20);

        // Single requester streaming 10 words with no bubbles.
        do_reset();
        load(2, 10);
        repeat (10) expect_src(2);
        drain("s33_drain", 40);
        check_eq("s33_beats", W'(nbeats), W'(10));
        check_eq("s33_span",  W'(last_cyc - first_cyc + 1), W'(10));

        // All requesters busy: bursts of MB rotating 0,1,2,3.
        do_reset();
        for (int k = 0; k < NR; k++) load(k, 4);
        for (int r = 0; r < 4 / MB; r++)
            for (int k = 0; k < NR; k++)
                for (int b = 0; b < MB; b++) expect_src(k);
        drain("s34_drain", 80);
        check_eq("s34_span", W'(last_cyc - first_cyc + 1), W'(16));

        // Output stall for 5 cycles: word held, no pops.
        do_reset();
        out_ready = 1'b0;
        load(0, 3);
        repeat (3) expect_src(0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_eq("s35_valid",   W'(out_valid),   W'(1));
            check_eq("s35_data",    out_data,        exp_q[0].data);
            check_eq("s35_src",     W'(out_src),     '0);
            check_eq("s35_consume", W'(req_consume), '0);
            cycle();
        end
        out_ready = 1'b1;
        drain("s35_drain", 20);

        // Requester 1 with one word, requester 3 with three.
        do_reset();
        load(1, 1);
        load(3, 3);
        expect_src(1);
        expect_src(3);
        expect_src(3);
        expect_src(3);
        drain("s36_drain", 20);
        check_eq("s36_span",  W'(last_cyc - first_cyc + 1), W'(4));
        check_eq("s36_idle",  W'(out_valid), '0);

        // Reset mid-burst between clock edges.
        do_reset();
        load(1, 6);
        load(3, 4);
        cycle();
        check_eq("s37_pre_valid", W'(out_valid), W'(1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("s37_rst_valid",   W'(out_valid),   '0);
        check_eq("s37_rst_data",    out_data,        '0);
        check_eq("s37_rst_consume", W'(req_consume), '0);
        void'(ref_q[1].pop_front());   // word discarded by reset
        @(posedge clk);
        #1;
        refresh();
        rst = 1'b0;
        clear_stats();
        foreach (t37[i]) expect_src(t37[i]);
        drain("s37_drain", 40);

        // en low with a word pending: delivered, then no pops until en returns.
        do_reset();
        out_ready = 1'b0;
        load(0, 3);
        repeat (3) expect_src(0);
        cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("s38_hold_consume", W'(req_consume), '0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        check_eq("s38_delivered", W'(exp_q.size()), W'(2));
        check_eq("s38_valid_clr", W'(out_valid),    '0);
        for (int i = 0; i < 3; i++) begin
            check_eq("s38_idle_consume", W'(req_consume), '0);
            check_eq("s38_idle_valid",   W'(out_valid),   '0);
            cycle();
        end
        en = 1'b1;
        drain("s38_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
